bcd_serial_adder: RTL
=====================

# bcd_serial_adder

Parametrised, digit-serial N-digit BCD adder/subtractor. It is the multi-digit successor to our single-digit combinational BCD adder. Operands are latched on a start pulse and processed one BCD digit per clock, least-significant digit first, with decimal carry correction. A one-cycle done pulse marks a registered, stable result that drives the existing per-digit 7-segment decoders on the board top level.

## Interface
- DIGITS, 4, number of BCD digits per operand; legal range 1..16.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the FSM is in IDLE or DONE.
- sub  in  1  0 = A+B, 1 = A−B (ten's complement); latched on an accepted start.
- cin  in  1  carry-in when sub=0, borrow-in when sub=1; latched on an accepted start.
- A  in  4*DIGITS  BCD operand; digit i is A[4i+3:4i].
- B  in  4*DIGITS  BCD operand, same packing.
- S  out  4*DIGITS  registered BCD result.
- cout  out  1  final decimal carry. In sub mode, 1 = no borrow (A ≥ B+cin).
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse when S, cout and invalid are updated.
- invalid  out  1  at least one digit of the latched A or B was > 9.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→DONE after exactly DIGITS digit cycles.
  - DONE→RUN on start, else DONE→IDLE.
- On an accepted start:
  - latch A and B into shift registers, and latch sub.
  - Initial carry c = sub ? ~cin : cin.
  - Clear the digit counter, and clear the internal invalid accumulator.
- Each RUN cycle, for current digits a and b:
  - b' = sub ? (9 − b) : b.
  - t = a + b' + c, 5-bit.
  - If t > 9: digit = (t + 6)[3:0] and c = 1.
  - Else: digit = t[3:0] and c = 0.
  - Shift the digit into the result shift register at the MS end, and shift A/B right by 4.
- Invalid detection: if a > 9 or b > 9 (raw b, before complement), set the invalid accumulator. Computation continues regardless.
- On entry to DONE, load the output registers:
  - S = result shift register, cout = c, invalid = accumulator.
  - If the accumulator is set: S = 0 and cout = 0 instead.
- Outputs S, cout and invalid hold between DONE events. They are unaffected by A/B/sub/cin changes while idle or running.
- start asserted in RUN is ignored; it is not queued.
- Inputs A, B, sub and cin may change freely after the start cycle.
- Digit counter width is clog2(DIGITS), minimum 1 bit. It terminates at count DIGITS−1, with no wrap into a new operation.

## Timing
- Reset (any state, including mid-RUN):
  - next cycle state = IDLE.
  - S = 0, cout = 0, busy = 0, done = 0, invalid = 0.
  - The partial result is discarded and no done is issued for the aborted operation.
- Reset has priority over start in the same cycle.
- start sampled high at edge k (state IDLE or DONE):
  - busy = 1 for cycles k+1 … k+DIGITS.
  - done = 1 in cycle k+DIGITS+1 only, with outputs updated in that same cycle.
- Latency is DIGITS+1 cycles from start to done.
- Throughput is one operation per DIGITS+1 cycles: start held high in DONE restarts immediately with no IDLE gap.
- busy and done are never high together. done is never high for two consecutive cycles.
- DIGITS=1: busy is high for exactly one cycle.

## Test plan
- DIGITS=4, sub=0, cin=0, A=0x1234, B=0x5678, start at cycle 0 → busy in cycles 1–4; done in cycle 5 with S=0x6912, cout=0, invalid=0.
- Add with carry ripple: A=0x9999, B=0x0001, cin=0 → S=0x0000, cout=1. Also A=0x0999, B=0x0000, cin=1 → S=0x1000, cout=0.
- Subtract: sub=1, cin=0.
  - A=0x5000, B=0x1234 → S=0x3766, cout=1.
  - A=0x1234, B=0x5000 → S=0x6234, cout=0.
  - A=0x0000, B=0x0000, cin=1 → S=0x9999, cout=0.
- Invalid digit: A=0x12A4, B=0x0001 → done with invalid=1, S=0, cout=0. Next valid start 0x0001+0x0001 → invalid=0, S=0x0002.
- Protocol edge cases:
  - start re-pulsed in cycle 2 of RUN is ignored; done still occurs in cycle 5 with the first result.
  - start held high through DONE begins a second operation, with done again 5 cycles later.
- Reset at cycle 3 mid-RUN → cycle 4 shows busy=0, S=0, cout=0, and no done pulse ever occurs.
- Repeat the add/carry cases with DIGITS=1 and DIGITS=8 (A=0x99999999, B=0x00000001 → S=0, cout=1).

Source files
------------

// File: rtl/bcd_serial_adder.sv
// Digit-serial N-digit BCD adder/subtractor.
// Operands are captured on an accepted start and consumed one BCD digit per
// clock, least-significant digit first. The result, final carry and the
// invalid-digit flag are registered on the last digit cycle and held until
// the next completed operation; done pulses for one cycle when they change.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_sub,
    input  logic                  i_cin,
    input  logic [4*DIGITS-1:0]   i_a,
    input  logic [4*DIGITS-1:0]   i_b,
    output logic [4*DIGITS-1:0]   o_s,
    output logic                  o_cout,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    // Operand shift registers and per-operation context
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sub;
    logic            r_c;
    logic [CW-1:0]   r_cnt;
    logic            r_inv;

    // Held outputs
    logic [W-1:0]    r_s;
    logic            r_cout;
    logic            r_invalid;

    // Digit-slice signals
    logic            w_accept;
    logic            w_last;
    logic [3:0]      w_a_dig;
    logic [3:0]      w_b_dig;
    logic [3:0]      w_b_eff;
    logic [4:0]      w_sum;
    logic [3:0]      w_adj;
    logic [3:0]      w_digit;
    logic            w_carry;
    logic            w_inv_next;
    logic [W-1:0]    w_res_next;

    // A new operation may begin only from IDLE or DONE; start during RUN is dropped.
    assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_RUN) && (r_cnt == LAST_DIGIT);

    // State register
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (r_cnt == LAST_DIGIT) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_done       = 1'b1;
                w_state_next = i_start ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // One BCD digit slice: complement for subtract, add, decimal-correct
    always_comb begin
        w_a_dig = r_a[3:0];
        w_b_dig = r_b[3:0];
        w_b_eff = r_sub ? (4'd9 - w_b_dig) : w_b_dig;
        w_sum   = {1'b0, w_a_dig} + {1'b0, w_b_eff} + {4'b0000, r_c};
        w_adj   = w_sum[3:0] + 4'd6;
        if (w_sum > 5'd9) begin
            w_digit = w_adj;
            w_carry = 1'b1;
        end else begin
            w_digit = w_sum[3:0];
            w_carry = 1'b0;
        end
        // Range check uses the raw B digit, before nine's complementing.
        w_inv_next = r_inv || (w_a_dig > 4'd9) || (w_b_dig > 4'd9);
    end

    // Result accumulator: digits enter at the MS end, so after DIGITS cycles
    // the first digit has travelled to the LS position. The final digit is
    // merged combinationally, leaving only DIGITS-1 digits to store.
    generate
        if (DIGITS > 1) begin : g_multi
            logic [W-5:0] r_res;

            // Shift the newly computed digit into the partial result
            always_ff @(posedge i_clk) begin
                // NOTE: r_res is pure datapath that is completely overwritten
                // before it is ever observed, so it carries no reset.
                if (r_state == S_RUN) begin
                    r_res <= w_res_next[W-1:4];
                end
            end

            assign w_res_next = {w_digit, r_res};
        end else begin : g_single
            assign w_res_next = w_digit;
        end
    endgenerate

    // Operand capture and per-digit sequencing
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sub <= 1'b0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            r_inv <= 1'b0;
        end else if (w_accept) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_sub <= i_sub;
            // Ten's complement subtract: a borrow-in becomes a missing +1.
            r_c   <= i_sub ? ~i_cin : i_cin;
            r_cnt <= '0;
            r_inv <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_a   <= r_a >> 4;
            r_b   <= r_b >> 4;
            r_c   <= w_carry;
            r_inv <= w_inv_next;
            // Counter parks at the last digit rather than wrapping.
            if (!w_last) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Output registers, loaded on the final digit so they change with done
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s       <= '0;
            r_cout    <= 1'b0;
            r_invalid <= 1'b0;
        end else if (w_last) begin
            r_invalid <= w_inv_next;
            if (w_inv_next) begin
                r_s    <= '0;
                r_cout <= 1'b0;
            end else begin
                r_s    <= w_res_next;
                r_cout <= w_carry;
            end
        end
    end

    assign o_s       = r_s;
    assign o_cout    = r_cout;
    assign o_invalid = r_invalid;

endmodule
